// File: rtl/led_share_arbiter.sv
// Round-robin time-sharing of one LED between debounced requesters, with a minimum on-time per
// grant. Defining LED_SHARE_BLINK_ID_EN makes the LED blink the owner's identity code.

module led_share_arbiter #(
   parameter int unsigned REQUESTER_COUNT    = 6,
   parameter int unsigned HOLD_COUNTER_WIDTH = 24,
   parameter int unsigned INDEX_WIDTH        = $clog2(REQUESTER_COUNT)
) (
   input  logic                          i_clock,
   input  logic                          i_reset_n,
   input  logic [REQUESTER_COUNT-1:0]    i_request,
   input  logic [HOLD_COUNTER_WIDTH-1:0] i_hold_cycles,
   input  logic [HOLD_COUNTER_WIDTH-1:0] i_blink_cycles,
   output logic                          o_led,
   output logic [REQUESTER_COUNT-1:0]    o_grant,
   output logic [INDEX_WIDTH-1:0]        o_grant_index,
   output logic                          o_busy
);

   localparam logic [INDEX_WIDTH-1:0]        LastIndex = INDEX_WIDTH'(REQUESTER_COUNT - 1);
   localparam logic [HOLD_COUNTER_WIDTH-1:0] CountOne  = HOLD_COUNTER_WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

   state_e                        r_state, w_state_next;
   logic [INDEX_WIDTH-1:0]        r_rr_ptr, w_rr_ptr_next;
   logic [REQUESTER_COUNT-1:0]    r_grant, w_grant_next;
   logic [INDEX_WIDTH-1:0]        r_grant_index, w_grant_index_next;
   logic                          r_led, w_led_next;
   logic                          r_busy, w_busy_next;
   logic [HOLD_COUNTER_WIDTH-1:0] r_hold_val, w_hold_val_next;
   logic [HOLD_COUNTER_WIDTH-1:0] r_hold_cnt, w_hold_cnt_next;

   logic                          w_found;
   logic [INDEX_WIDTH-1:0]        w_sel_index;
   logic [INDEX_WIDTH-1:0]        w_pos;
   logic                          w_hold_done;
   logic                          w_owner_req;
   logic                          w_other_pending;
   logic                          w_seq_done;
   logic                          w_led_grant;

   // First set request at or above rr_ptr, wrapping around.
   always_comb begin
      w_found     = 1'b0;
      w_sel_index = '0;
      w_pos       = r_rr_ptr;
      for (int k = 0; k < int'(REQUESTER_COUNT); k++) begin
         if (!w_found && i_request[w_pos]) begin
            w_found     = 1'b1;
            w_sel_index = w_pos;
         end
         w_pos = (w_pos == LastIndex) ? '0 : w_pos + 1'b1;
      end
   end

   assign w_hold_done     = (r_hold_cnt >= (r_hold_val - CountOne));
   assign w_owner_req     = i_request[r_grant_index];
   assign w_other_pending = |(i_request & ~r_grant);

`ifdef LED_SHARE_BLINK_ID_EN
   localparam int unsigned BlinkWidth = HOLD_COUNTER_WIDTH + 2;

   logic [HOLD_COUNTER_WIDTH-1:0] r_blink_val, w_blink_val_next;
   logic [BlinkWidth-1:0]         r_blink_cnt, w_blink_cnt_next;
   logic [BlinkWidth-1:0]         w_phase_len;
   logic [INDEX_WIDTH:0]          r_phase, w_phase_next;
   logic [INDEX_WIDTH:0]          w_last_phase;
   logic                          w_phase_end;

   // Even phases are pulses, odd phases are lows; the final odd phase is the long gap.
   assign w_last_phase = {r_grant_index, 1'b1};
   assign w_phase_len  = (r_phase == w_last_phase) ? {r_blink_val, 2'b00} : {2'b00, r_blink_val};
   assign w_phase_end  = (r_blink_cnt == (w_phase_len - 1'b1));
   assign w_seq_done   = (r_phase == w_last_phase) && w_phase_end;

   always_comb begin
      w_blink_val_next = r_blink_val;
      w_blink_cnt_next = r_blink_cnt;
      w_phase_next     = r_phase;
      if (r_state == StIdle && w_state_next == StGrant) begin
         w_blink_val_next = (i_blink_cycles == '0) ? CountOne : i_blink_cycles;
         w_blink_cnt_next = '0;
         w_phase_next     = '0;
      end else if (r_state == StGrant) begin
         if (w_phase_end) begin
            w_blink_cnt_next = '0;
            w_phase_next     = w_seq_done ? '0 : r_phase + 1'b1;
         end else begin
            w_blink_cnt_next = r_blink_cnt + 1'b1;
         end
      end
   end

   assign w_led_grant = ~w_phase_next[0];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_blink_val <= '0;
         r_blink_cnt <= '0;
         r_phase     <= '0;
      end else begin
         r_blink_val <= w_blink_val_next;
         r_blink_cnt <= w_blink_cnt_next;
         r_phase     <= w_phase_next;
      end
   end
`else
   logic w_unused_blink;

   assign w_seq_done     = 1'b1;
   assign w_led_grant    = 1'b1;
   assign w_unused_blink = ^i_blink_cycles;
`endif

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_found) begin
               w_state_next = StGrant;
            end
         end
         StGrant: begin
            if (w_hold_done && w_seq_done && (!w_owner_req || w_other_pending)) begin
               w_state_next = StRelease;
            end
         end
         StRelease: w_state_next = StIdle;
         default:   w_state_next = StIdle;
      endcase
   end

   // Next values of the registered outputs and timers.
   always_comb begin
      w_led_next         = r_led;
      w_grant_next       = r_grant;
      w_grant_index_next = r_grant_index;
      w_busy_next        = r_busy;
      w_hold_val_next    = r_hold_val;
      w_hold_cnt_next    = r_hold_cnt;
      w_rr_ptr_next      = r_rr_ptr;
      unique case (r_state)
         StIdle: begin
            if (w_state_next == StGrant) begin
               w_led_next         = w_led_grant;
               w_grant_next       = REQUESTER_COUNT'(1) << w_sel_index;
               w_grant_index_next = w_sel_index;
               w_busy_next        = 1'b1;
               w_hold_val_next    = (i_hold_cycles == '0) ? CountOne : i_hold_cycles;
               w_hold_cnt_next    = '0;
            end else begin
               w_led_next   = 1'b0;
               w_grant_next = '0;
               w_busy_next  = 1'b0;
            end
         end
         StGrant: begin
            if (r_hold_cnt != r_hold_val) begin
               w_hold_cnt_next = r_hold_cnt + 1'b1;
            end
            w_busy_next = 1'b1;
            if (w_state_next == StRelease) begin
               w_led_next   = 1'b0;
               w_grant_next = '0;
            end else begin
               w_led_next = w_led_grant;
            end
         end
         StRelease: begin
            w_led_next    = 1'b0;
            w_grant_next  = '0;
            w_busy_next   = 1'b0;
            w_rr_ptr_next = (r_grant_index == LastIndex) ? '0 : r_grant_index + 1'b1;
         end
         default: begin
            w_led_next   = 1'b0;
            w_grant_next = '0;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_led         <= 1'b0;
         r_grant       <= '0;
         r_grant_index <= '0;
         r_busy        <= 1'b0;
         r_hold_val    <= '0;
         r_hold_cnt    <= '0;
         r_rr_ptr      <= '0;
      end else begin
         r_led         <= w_led_next;
         r_grant       <= w_grant_next;
         r_grant_index <= w_grant_index_next;
         r_busy        <= w_busy_next;
         r_hold_val    <= w_hold_val_next;
         r_hold_cnt    <= w_hold_cnt_next;
         r_rr_ptr      <= w_rr_ptr_next;
      end
   end

   assign o_led         = r_led;
   assign o_grant       = r_grant;
   assign o_grant_index = r_grant_index;
   assign o_busy        = r_busy;

endmodule
